toycpu_bus_responder: RTL
=========================

Name: toycpu_bus_responder

Overview:
- Memory/peripheral responder on the far end of the toy CPU's 4-bit-address, 8-bit-data bus, serving CPU reads and writes.
- 16 x 8 register-file memory, with two top addresses remapped to an input port and an output port.
- Serial program loader: an external host writes memory while the CPU is held.
- Sits beside the CPU inside the top-level wrapper. Bus pins connect directly; loader and port pins go to spare ui/uo/uio pins.

Parameters:
- IN_ADDR, 4'hE, address that reads the synchronised input port (read-only).
- OUT_ADDR, 4'hF, address of the output-port register (read/write).
- SYNC_STAGES, 2, flop stages on in_port (legal values 1..3).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_addr  in  4  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_rdata  out  8  read data, combinational from cpu_addr.
- cpu_hold  out  1  high while the loader owns the memory; CPU must stall.
- ld_en  in  1  loader session enable.
- ld_valid  in  1  ld_bit is valid this cycle.
- ld_bit  in  1  serial frame bit, MSB first.
- ld_done  out  1  one-cycle pulse when a frame is committed.
- in_port  in  8  asynchronous external inputs.
- out_port  out  8  output-port register.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All 16 memory words = 0, out_port = 0, sync flops = 0.
  - Loader goes to IDLE with bit count 0 and shift register 0.
  - cpu_hold = 0, ld_done = 0.
  - Reset mid-frame discards the partial frame; no write occurs.
- Read path (zero latency):
  - cpu_rdata = synced in_port when cpu_addr == IN_ADDR.
  - cpu_rdata = out_port when cpu_addr == OUT_ADDR.
  - Otherwise cpu_rdata = mem[cpu_addr].
  - Valid during cpu_hold as well; contents may change under the loader.
- CPU write: at a clk edge with cpu_we=1 and cpu_hold=0:
  - OUT_ADDR: out_port <= cpu_wdata.
  - IN_ADDR: write is dropped.
  - Otherwise mem[cpu_addr] <= cpu_wdata.
  - Read-after-write is visible from the next cycle.
  - cpu_we while cpu_hold=1 is ignored entirely.
- Loader FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: cpu_hold=0. If ld_en=1, go to SHIFT with count=0. ld_valid is ignored in IDLE.
  - SHIFT: cpu_hold=1.
    - Each cycle with ld_valid=1: shift ld_bit in, count++.
    - ld_valid=0: hold (stall, no timeout).
    - When the 12th bit is accepted (count 11 -> 12), go to COMMIT.
    - ld_en=0 at any point: go to IDLE, partial frame discarded, count=0. This takes priority over a simultaneous valid bit.
  - Frame format: bits[11:8] = address, bits[7:0] = data, address MSB first.
  - COMMIT (one cycle): cpu_hold=1, ld_done=1.
    - Writes data with the same address decode as a CPU write (IN_ADDR dropped, OUT_ADDR updates out_port).
    - Then SHIFT with count=0 if ld_en=1, else IDLE.
    - ld_valid is ignored in COMMIT; bits presented that cycle are lost.
- cpu_hold is registered state: it rises the cycle after ld_en is first seen in IDLE, and falls the cycle after leaving SHIFT/COMMIT.
- Count is 4 bits and never wraps past 12.
- in_port passes through SYNC_STAGES flops, so its read latency is SYNC_STAGES cycles.

Decomposition:
- Shared package toycpu_pkg holds:
  - ADDR_W=4, DATA_W=8, FRAME_BITS=12.
  - Default IN_ADDR/OUT_ADDR constants.
  - The loader state enum (IDLE, SHIFT, COMMIT).
- One sub-module: toycpu_serial_loader (FSM, counter, shift register). Outputs: frame address, frame data, commit strobe, hold.
- Memory, port mapping and write arbitration stay in the parent.

Test Plan:
- Reset, then read all 16 addresses -> cpu_rdata=0x00 everywhere; out_port=0x00, cpu_hold=0.
- CPU writes 0xA5 to addr 3 and 0x3C to addr 15 -> next cycle rdata(3)=0xA5; out_port=0x3C and rdata(15)=0x3C.
- CPU write 0xFF to addr 14 with in_port=0x81 -> rdata(14)=0x81 SYNC_STAGES cycles after in_port settles; write has no effect.
- ld_en=1, stream frame 0x2_7E with ld_valid gaps -> cpu_hold=1 throughout, one ld_done pulse, rdata(2)=0x7E. A cpu_we to addr 2 with 0x11 during hold is ignored.
- Two back-to-back frames (0x0_11, 0xF_22) without dropping ld_en -> two ld_done pulses; mem[0]=0x11, out_port=0x22.
- Drop ld_en after 7 bits, and separately pulse rst_n low after 9 bits -> no write, cpu_hold=0 next cycle; rst_n case also clears memory.

Source files
------------

// File: rtl/toycpu_pkg.sv
// toycpu_pkg: shared widths, default port addresses and loader state encoding
package toycpu_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int FRAME_BITS = 12;
  localparam logic [ADDR_W-1:0] IN_ADDR_DEF = 4'hE;
  localparam logic [ADDR_W-1:0] OUT_ADDR_DEF = 4'hF;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} ld_state_e;
endpackage

// File: rtl/toycpu_serial_loader.sv
// toycpu_serial_loader: collects 12-bit address/data frames MSB first and strobes a commit
module toycpu_serial_loader
  import toycpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic              ld_valid,
  input  logic              ld_bit,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              commit,
  output logic              hold
);
  ld_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [FRAME_BITS-1:0] sr, sr_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    case (state)
      IDLE: begin
        state_n = ld_en ? SHIFT : IDLE;
        cnt_n = '0;
      end
      SHIFT: begin
        if (!ld_en) begin
          state_n = IDLE;
          cnt_n = '0;
        end else if (ld_valid) begin
          sr_n = {sr[FRAME_BITS-2:0], ld_bit};
          cnt_n = cnt + 4'd1;
          state_n = (cnt == 4'(FRAME_BITS - 1)) ? COMMIT : SHIFT;
        end
      end
      COMMIT: begin
        state_n = ld_en ? SHIFT : IDLE;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  assign frame_addr = sr[FRAME_BITS-1:DATA_W];
  assign frame_data = sr[DATA_W-1:0];
  assign commit = (state == COMMIT);
  assign hold = (state != IDLE);
endmodule

// File: rtl/toycpu_bus_responder.sv
// toycpu_bus_responder: 16x8 memory with mapped in/out ports and serial program loader
module toycpu_bus_responder
  import toycpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IN_ADDR = IN_ADDR_DEF,
  parameter logic [ADDR_W-1:0] OUT_ADDR = OUT_ADDR_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              ld_en,
  input  logic              ld_valid,
  input  logic              ld_bit,
  output logic              ld_done,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] sync_q [SYNC_STAGES];
  logic [ADDR_W-1:0] f_addr, wa;
  logic [DATA_W-1:0] f_data, wd;
  logic commit, hold, we;
  toycpu_serial_loader u_loader (
    .clk(clk),
    .rst_n(rst_n),
    .ld_en(ld_en),
    .ld_valid(ld_valid),
    .ld_bit(ld_bit),
    .frame_addr(f_addr),
    .frame_data(f_data),
    .commit(commit),
    .hold(hold)
  );
  assign we = commit | (cpu_we & ~hold);
  assign wa = commit ? f_addr : cpu_addr;
  assign wd = commit ? f_data : cpu_wdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      out_port <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      if (we && wa == OUT_ADDR) out_port <= wd;
      else if (we && wa != IN_ADDR) mem[wa] <= wd;
    end
  end
  assign cpu_rdata = (cpu_addr == IN_ADDR) ? sync_q[SYNC_STAGES-1] :
                     (cpu_addr == OUT_ADDR) ? out_port : mem[cpu_addr];
  assign cpu_hold = hold;
  assign ld_done = commit;
endmodule
